// File: rtl/coreriscv_axi4_bp_csr_file.sv
// Trigger/breakpoint CSR file: owns tselect/tdata1/tdata2 and drives the per-breakpoint
// control and address registers read by the pipeline's breakpoint comparator.
module coreriscv_axi4_bp_csr_file #(
  parameter int NBP     = 2,
  parameter int MASKMAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              csr_req_valid,
  output logic              csr_req_ready,
  input  logic [1:0]        csr_req_cmd,
  input  logic [11:0]       csr_req_addr,
  input  logic [31:0]       csr_req_wdata,
  input  logic [1:0]        csr_status_prv,
  output logic              csr_rsp_valid,
  input  logic              csr_rsp_ready,
  output logic [31:0]       csr_rsp_rdata,
  output logic              csr_rsp_err,
  output logic [4*NBP-1:0]  bp_control_bpmatch,
  output logic [4*NBP-1:0]  bp_control_mhsu,
  output logic [3*NBP-1:0]  bp_control_rwx,
  output logic [32*NBP-1:0] bp_address,
  output logic              dbg_state
);

  // Handshake: a request transfers on a cycle with csr_req_valid && csr_req_ready; the
  // response transfers on a cycle with csr_rsp_valid && csr_rsp_ready. rsp data is held
  // stable while csr_rsp_valid is high and not yet accepted.
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t      state;
  logic [2:0]  tselect;
  int unsigned sel;
  logic [3:0]  sel_bpmatch;
  logic [3:0]  sel_mhsu;
  logic [2:0]  sel_rwx;
  logic [31:0] sel_addr;
  logic [31:0] tdata1_val;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic [3:0]  wr_bpmatch;
  logic        bpmatch_ok;
  logic        acc_err;
  logic        req_fire;
  logic        do_write;

  assign dbg_state = (state == RESP);

  always_comb begin
    sel         = 32'(tselect);
    sel_bpmatch = bp_control_bpmatch[4*sel +: 4];
    sel_mhsu    = bp_control_mhsu[4*sel +: 4];
    sel_rwx     = bp_control_rwx[3*sel +: 3];
    sel_addr    = bp_address[32*sel +: 32];
    tdata1_val  = {4'd1, 5'(MASKMAX), 4'd0, 8'd0, sel_bpmatch, sel_mhsu, sel_rwx};

    acc_err = (csr_req_addr < 12'h7A0) || (csr_req_addr > 12'h7A2) ||
              ((csr_req_cmd != 2'd0) && (csr_status_prv != 2'd3));

    case (csr_req_addr)
      12'h7A0: old_val = {29'd0, tselect};
      12'h7A1: old_val = tdata1_val;
      12'h7A2: old_val = sel_addr;
      default: old_val = 32'd0;
    endcase

    case (csr_req_cmd)
      2'd1:    new_val = csr_req_wdata;
      2'd2:    new_val = old_val | csr_req_wdata;
      2'd3:    new_val = old_val & ~csr_req_wdata;
      default: new_val = old_val;
    endcase

    // Range match needs the previous breakpoint as its lower bound, so bp0 cannot use it.
    wr_bpmatch = new_val[10:7];
    bpmatch_ok = (wr_bpmatch == 4'd0) || (wr_bpmatch == 4'd2) ||
                 ((wr_bpmatch == 4'd1) && (tselect != 3'd0));

    req_fire = csr_req_valid && csr_req_ready;
    do_write = req_fire && !acc_err && (csr_req_cmd != 2'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      tselect            <= 3'd0;
      csr_req_ready      <= 1'b1;
      csr_rsp_valid      <= 1'b0;
      csr_rsp_rdata      <= 32'd0;
      csr_rsp_err        <= 1'b0;
      bp_control_bpmatch <= '0;
      bp_control_mhsu    <= '0;
      bp_control_rwx     <= '0;
      bp_address         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            state         <= RESP;
            csr_req_ready <= 1'b0;
            csr_rsp_valid <= 1'b1;
            csr_rsp_rdata <= acc_err ? 32'd0 : old_val;
            csr_rsp_err   <= acc_err;
          end
        end
        RESP: begin
          if (csr_rsp_ready) begin
            state         <= IDLE;
            csr_rsp_valid <= 1'b0;
            csr_req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (do_write) begin
        case (csr_req_addr)
          12'h7A0: begin
            if (new_val < 32'(NBP)) tselect <= new_val[2:0];
          end
          12'h7A1: begin
            if (bpmatch_ok) bp_control_bpmatch[4*sel +: 4] <= wr_bpmatch;
            bp_control_mhsu[4*sel +: 4] <= new_val[6:3];
            bp_control_rwx[3*sel +: 3]  <= new_val[2:0];
          end
          12'h7A2: bp_address[32*sel +: 32] <= new_val;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coreriscv_axi4_bp_csr_file.sv
// Bench for the breakpoint CSR file: directed vector table, hand-written handshake/reset
// sequences, and randomized accesses checked against a field-level model.
module tb_coreriscv_axi4_bp_csr_file;
  localparam int NBP     = 2;
  localparam int MASKMAX = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              csr_req_valid;
  logic              csr_req_ready;
  logic [1:0]        csr_req_cmd;
  logic [11:0]       csr_req_addr;
  logic [31:0]       csr_req_wdata;
  logic [1:0]        csr_status_prv;
  logic              csr_rsp_valid;
  logic              csr_rsp_ready;
  logic [31:0]       csr_rsp_rdata;
  logic              csr_rsp_err;
  logic [4*NBP-1:0]  bp_control_bpmatch;
  logic [4*NBP-1:0]  bp_control_mhsu;
  logic [3*NBP-1:0]  bp_control_rwx;
  logic [32*NBP-1:0] bp_address;
  logic              dbg_state;

  coreriscv_axi4_bp_csr_file #(.NBP(NBP), .MASKMAX(MASKMAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
    .csr_req_cmd(csr_req_cmd), .csr_req_addr(csr_req_addr),
    .csr_req_wdata(csr_req_wdata), .csr_status_prv(csr_status_prv),
    .csr_rsp_valid(csr_rsp_valid), .csr_rsp_ready(csr_rsp_ready),
    .csr_rsp_rdata(csr_rsp_rdata), .csr_rsp_err(csr_rsp_err),
    .bp_control_bpmatch(bp_control_bpmatch), .bp_control_mhsu(bp_control_mhsu),
    .bp_control_rwx(bp_control_rwx), .bp_address(bp_address),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: breakpoint fields kept as plain per-breakpoint arrays
  int unsigned m_tsel;
  int unsigned m_bpm[NBP];
  int unsigned m_mhsu[NBP];
  int unsigned m_rwx[NBP];
  int unsigned m_addr[NBP];

  function automatic void model_reset();
    m_tsel = 0;
    for (int i = 0; i < NBP; i++) begin
      m_bpm[i] = 0; m_mhsu[i] = 0; m_rwx[i] = 0; m_addr[i] = 0;
    end
  endfunction

  function automatic int unsigned model_tdata1();
    return (1 << 28) + (MASKMAX << 23) + (m_bpm[m_tsel] << 7) +
           (m_mhsu[m_tsel] << 3) + m_rwx[m_tsel];
  endfunction

  function automatic void model_access(input int unsigned cmd, input int unsigned addr,
                                       input int unsigned wd, input int unsigned prv,
                                       output logic [31:0] rd, output logic err);
    int unsigned old_v, new_v, f;
    err = (addr < 'h7A0) || (addr > 'h7A2) || (cmd != 0 && prv != 3);
    case (addr)
      'h7A0:   old_v = m_tsel;
      'h7A1:   old_v = model_tdata1();
      'h7A2:   old_v = m_addr[m_tsel];
      default: old_v = 0;
    endcase
    rd = err ? 32'd0 : old_v;
    if (err || cmd == 0) return;
    if (cmd == 1)      new_v = wd;
    else if (cmd == 2) new_v = old_v | wd;
    else               new_v = old_v & ~wd;
    if (addr == 'h7A0) begin
      if (new_v < NBP) m_tsel = new_v;
    end else if (addr == 'h7A1) begin
      f = (new_v / 128) % 16;
      if (f == 0 || f == 2 || (f == 1 && m_tsel >= 1)) m_bpm[m_tsel] = f;
      m_mhsu[m_tsel] = (new_v / 8) % 16;
      m_rwx[m_tsel]  = new_v % 8;
    end else begin
      m_addr[m_tsel] = new_v;
    end
  endfunction

  task automatic check_bp_outputs(input string tag);
    logic [4*NBP-1:0]  e_bpm, e_mhsu;
    logic [3*NBP-1:0]  e_rwx;
    logic [32*NBP-1:0] e_addr;
    for (int i = 0; i < NBP; i++) begin
      e_bpm[4*i +: 4]   = 4'(m_bpm[i]);
      e_mhsu[4*i +: 4]  = 4'(m_mhsu[i]);
      e_rwx[3*i +: 3]   = 3'(m_rwx[i]);
      e_addr[32*i +: 32] = m_addr[i];
    end
    check({tag, "_bpmatch"}, 256'(bp_control_bpmatch), 256'(e_bpm));
    check({tag, "_mhsu"}, 256'(bp_control_mhsu), 256'(e_mhsu));
    check({tag, "_rwx"}, 256'(bp_control_rwx), 256'(e_rwx));
    check({tag, "_address"}, 256'(bp_address), 256'(e_addr));
  endtask

  // driver: one full request/response; hold = cycles rsp_ready stays low after rsp_valid
  task automatic do_access(input logic [1:0] cmd, input logic [11:0] addr,
                           input logic [31:0] wd, input logic [1:0] prv, input int hold,
                           output logic [31:0] rd, output logic e);
    @(negedge clk);
    check("req_ready_idle", 256'(csr_req_ready), 256'(1));
    csr_req_valid  = 1'b1;
    csr_req_cmd    = cmd;
    csr_req_addr   = addr;
    csr_req_wdata  = wd;
    csr_status_prv = prv;
    @(negedge clk);
    csr_req_valid = 1'b0;
    check("rsp_valid_latency", 256'(csr_rsp_valid), 256'(1));
    rd = csr_rsp_rdata;
    e  = csr_rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rsp_valid_held", 256'(csr_rsp_valid), 256'(1));
      check("req_ready_busy", 256'(csr_req_ready), 256'(0));
    end
    csr_rsp_ready = 1'b1;
    @(negedge clk);
    csr_rsp_ready = 1'b0;
    check("rsp_done", 256'({csr_rsp_valid, csr_req_ready}), 256'(2'b01));
  endtask

  task automatic run_access(input logic [1:0] cmd, input logic [11:0] addr,
                            input logic [31:0] wd, input logic [1:0] prv, input int hold);
    logic [31:0] rd, exp_rd;
    logic        e, exp_e;
    model_access(cmd, addr, wd, prv, exp_rd, exp_e);
    do_access(cmd, addr, wd, prv, hold, rd, e);
    check("rand_rdata", 256'(rd), 256'(exp_rd));
    check("rand_err", 256'(e), 256'(exp_e));
    check_bp_outputs("rand");
  endtask

  typedef struct {
    logic [1:0]  cmd;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [1:0]  prv;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[21];
  logic [31:0] exp_q[$];

  initial begin
    logic [31:0] rd, mrd;
    logic        e, me;
    int          nt;

    vecs[0]  = '{2'd0, 12'h7A1, 32'h0,         2'd0, 32'h1200_0000, 1'b0};
    vecs[1]  = '{2'd1, 12'h7A0, 32'h1,         2'd3, 32'h0,         1'b0};
    vecs[2]  = '{2'd1, 12'h7A2, 32'h8000_1000, 2'd3, 32'h0,         1'b0};
    vecs[3]  = '{2'd1, 12'h7A1, 32'h0000_00C1, 2'd3, 32'h1200_0000, 1'b0};
    vecs[4]  = '{2'd0, 12'h7A1, 32'h0,         2'd3, 32'h1200_00C1, 1'b0};
    vecs[5]  = '{2'd1, 12'h7A0, 32'h0,         2'd3, 32'h1,         1'b0};
    vecs[6]  = '{2'd1, 12'h7A1, 32'h0000_0080, 2'd3, 32'h1200_0000, 1'b0};
    vecs[7]  = '{2'd0, 12'h7A1, 32'h0,         2'd3, 32'h1200_0000, 1'b0};
    vecs[8]  = '{2'd1, 12'h7A1, 32'h0000_0100, 2'd3, 32'h1200_0000, 1'b0};
    vecs[9]  = '{2'd0, 12'h7A1, 32'h0,         2'd1, 32'h1200_0100, 1'b0};
    vecs[10] = '{2'd2, 12'h7A1, 32'h1,         2'd3, 32'h1200_0100, 1'b0};
    vecs[11] = '{2'd3, 12'h7A1, 32'h1,         2'd3, 32'h1200_0101, 1'b0};
    vecs[12] = '{2'd0, 12'h7A1, 32'h0,         2'd3, 32'h1200_0100, 1'b0};
    vecs[13] = '{2'd1, 12'h7A2, 32'h0000_DEAD, 2'd0, 32'h0,         1'b1};
    vecs[14] = '{2'd0, 12'h7A2, 32'h0,         2'd0, 32'h0,         1'b0};
    vecs[15] = '{2'd0, 12'h7A5, 32'h0,         2'd3, 32'h0,         1'b1};
    vecs[16] = '{2'd1, 12'h7A0, 32'h5,         2'd3, 32'h0,         1'b0};
    vecs[17] = '{2'd0, 12'h7A0, 32'h0,         2'd3, 32'h0,         1'b0};
    vecs[18] = '{2'd1, 12'h7A0, 32'h1,         2'd3, 32'h0,         1'b0};
    vecs[19] = '{2'd0, 12'h7A2, 32'h0,         2'd3, 32'h8000_1000, 1'b0};
    vecs[20] = '{2'd2, 12'h7A1, 32'h2,         2'd1, 32'h0,         1'b1};

    reset_n = 1'b0;
    csr_req_valid = 1'b0; csr_req_cmd = 2'd0; csr_req_addr = 12'h0;
    csr_req_wdata = 32'h0; csr_status_prv = 2'd3; csr_rsp_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_req_ready", 256'(csr_req_ready), 256'(1));
    check("reset_rsp", 256'({csr_rsp_valid, csr_rsp_err, csr_rsp_rdata}), 256'(0));
    check_bp_outputs("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      model_access(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].prv, mrd, me);
      do_access(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].prv, i % 3, rd, e);
      check($sformatf("vec%0d_rdata", i), 256'(rd), 256'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_err", i), 256'(e), 256'(vecs[i].exp_err));
      check_bp_outputs($sformatf("vec%0d", i));
      if (i == 3) begin
        check("bp1_address", 256'(bp_address[63:32]), 256'(32'h8000_1000));
        check("bp1_bpmatch", 256'(bp_control_bpmatch[7:4]), 256'(4'd1));
        check("bp1_mhsu", 256'(bp_control_mhsu[7:4]), 256'(4'b1000));
        check("bp1_rwx", 256'(bp_control_rwx[5:3]), 256'(3'b001));
      end
      if (i == 6) check("bp0_range_rejected", 256'(bp_control_bpmatch[3:0]), 256'(0));
      if (i == 8) check("bp0_masked", 256'(bp_control_bpmatch[3:0]), 256'(4'd2));
    end

    // stalled response: extra request while busy must be ignored, rdata held
    nt = (m_tsel == 0) ? 1 : 0;
    model_access(0, 'h7A0, 0, 0, mrd, me);
    exp_q.push_back(mrd);
    @(negedge clk);
    csr_req_valid = 1'b1; csr_req_cmd = 2'd0; csr_req_addr = 12'h7A0;
    csr_req_wdata = 32'h0; csr_status_prv = 2'd0;
    @(negedge clk);
    csr_req_cmd = 2'd1; csr_req_wdata = 32'(nt); csr_status_prv = 2'd3;
    for (int i = 0; i < 4; i++) begin
      check("stall_rsp_valid", 256'(csr_rsp_valid), 256'(1));
      check("stall_rdata", 256'(csr_rsp_rdata), 256'(exp_q[0]));
      check("stall_req_ready", 256'(csr_req_ready), 256'(0));
      @(negedge clk);
    end
    void'(exp_q.pop_front());
    csr_req_valid = 1'b0;
    csr_rsp_ready = 1'b1;
    @(negedge clk);
    csr_rsp_ready = 1'b0;
    check("stall_release", 256'({csr_rsp_valid, csr_req_ready}), 256'(2'b01));
    run_access(2'd0, 12'h7A0, 32'h0, 2'd0, 0);

    // reset while a response is pending
    @(negedge clk);
    csr_req_valid = 1'b1; csr_req_cmd = 2'd1; csr_req_addr = 12'h7A2;
    csr_req_wdata = 32'h1234_5678; csr_status_prv = 2'd3;
    @(negedge clk);
    csr_req_valid = 1'b0;
    check("midrsp_valid", 256'(csr_rsp_valid), 256'(1));
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_rsp_valid", 256'(csr_rsp_valid), 256'(0));
    check("async_rst_req_ready", 256'(csr_req_ready), 256'(1));
    check_bp_outputs("async_rst");
    @(negedge clk);
    check_bp_outputs("rst_low");
    reset_n = 1'b1;
    run_access(2'd0, 12'h7A1, 32'h0, 2'd3, 0);

    // randomized accesses against the model
    for (int i = 0; i < 300; i++) begin
      logic [1:0]  c, p;
      logic [11:0] a;
      logic [31:0] w;
      c = 2'($urandom_range(0, 3));
      p = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'd3;
      a = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(12'h79E, 12'h7A6))
                                      : 12'($urandom_range(12'h7A0, 12'h7A2));
      w = $urandom;
      if (a == 12'h7A0) w = 32'($urandom_range(0, 7));
      if (a == 12'h7A1 && $urandom_range(0, 1) == 1) w[10:7] = 4'($urandom_range(0, 3));
      run_access(c, a, w, p, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
